// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB3 bridge: transfer types, responses and FSM states.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_t;

endpackage

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave turning each accepted single transfer into one APB3 SETUP/ACCESS pair.
// Every bus-facing output is a register loaded from the next-state decode.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY_IN,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADY_OUT,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic [1:0]            hresp_q, hresp_d;
  logic                  hready_q, hready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  accept_s;

  assign accept_s = HSEL & HREADY_IN &
                    ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // Next-state decode; outputs are derived from the state being entered so they register cleanly.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    case (state_q)
      // DONE and ERR2 are address-phase cycles too, which gives back-to-back transfers.
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept_s) begin
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          state_d  = HWRITE ? ST_WDATA : ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        pwdata_d = HWDATA;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!pwrite_q) begin
              hrdata_d = PRDATA;
            end else begin
              hrdata_d = hrdata_q;
            end
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
    hready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d   = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      hresp_q   <= HRESP_OKAY;
      hready_q  <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      hresp_q   <= hresp_d;
      hready_q  <= hready_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign HRDATA     = hrdata_q;
  assign HRESP      = hresp_q;
  assign HREADY_OUT = hready_q;
  assign PADDR      = paddr_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: inputs change 1 time unit after each rising edge,
// outputs are compared at that same point against hand-computed values.
module tb_ahb_apb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY_IN;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREADY_OUT;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp;
  int n_fail;

  ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY_IN(HREADY_IN), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HRESP(HRESP), .HREADY_OUT(HREADY_OUT), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_addr(input logic sel, input logic [1:0] trans,
                            input logic [31:0] addr, input logic wr);
    HSEL      = sel;
    HTRANS    = trans;
    HADDR     = addr;
    HWRITE    = wr;
    HREADY_IN = 1'b1;
  endtask

  task automatic drive_idle();
    drive_addr(1'b0, 2'b00, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive_idle();
    HWDATA = 32'h0; PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, HREADY_OUT, HRESP} !== 6'b0_0_0_1_00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want %b", {PSEL, PENABLE, PWRITE, HREADY_OUT, HRESP}, 6'b0_0_0_1_00);
    end
    n_cmp++;
    if ({HRDATA, PADDR, PWDATA} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {HRDATA, PADDR, PWDATA});
    end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
    drive_addr(1'b1, 2'b10, 32'h0000_0010, 1'b0);
    tick(); drive_idle();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, HREADY_OUT} !== 4'b1_0_0_0 || PADDR !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL read_t1_setup: got %b addr %h want 1000 addr 00000010", {PSEL, PENABLE, PWRITE, HREADY_OUT}, PADDR);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, HREADY_OUT} !== 3'b1_1_0) begin
      n_fail++;
      $display("FAIL read_t2_access: got %b want 110", {PSEL, PENABLE, HREADY_OUT});
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== 5'b0_0_1_00 || HRDATA !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL read_t3_done: got %b data %h want 00100 data deadbeef", {PSEL, PENABLE, HREADY_OUT, HRESP}, HRDATA);
    end
    tick();
  endtask

  task automatic test_write_wait();
    PREADY = 1'b0;
    drive_addr(1'b1, 2'b10, 32'h0000_0020, 1'b1);
    tick(); drive_idle();
    HWDATA = 32'h1234_5678;
    n_cmp++;
    if ({PSEL, HREADY_OUT} !== 2'b0_0) begin
      n_fail++;
      $display("FAIL write_t1_wdata: got %b want 00", {PSEL, HREADY_OUT});
    end
    tick();
    HWDATA = 32'hFFFF_0000;
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b1_0_1 || PADDR !== 32'h0000_0020 || PWDATA !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL write_setup: got %b addr %h data %h want 101 addr 00000020 data 12345678", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, PWRITE, HREADY_OUT} !== 4'b1_1_1_0 || PADDR !== 32'h0000_0020 || PWDATA !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL write_wait%0d: got %b addr %h data %h want 1110 addr 00000020 data 12345678", i, {PSEL, PENABLE, PWRITE, HREADY_OUT}, PADDR, PWDATA);
      end
    end
    tick();
    PREADY = 1'b1;
    n_cmp++;
    if ({PSEL, PENABLE, HREADY_OUT} !== 3'b1_1_0) begin
      n_fail++;
      $display("FAIL write_pready_cycle: got %b want 110", {PSEL, PENABLE, HREADY_OUT});
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== 5'b0_0_1_00 || HRDATA !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_done: got %b hrdata %h want 00100 hrdata deadbeef", {PSEL, PENABLE, HREADY_OUT, HRESP}, HRDATA);
    end
    tick();
    n_cmp++;
    if ({PADDR, PWRITE, PWDATA} !== {32'h0000_0020, 1'b1, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL write_hold: got %h %b %h want 00000020 1 12345678", PADDR, PWRITE, PWDATA);
    end
  endtask

  task automatic test_error();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5555_AAAA;
    drive_addr(1'b1, 2'b10, 32'h0000_0030, 1'b0);
    tick(); drive_idle();
    tick();
    tick();
    drive_addr(1'b1, 2'b10, 32'h0000_0034, 1'b0);
    n_cmp++;
    if ({PSEL, HREADY_OUT, HRESP} !== 4'b0_0_01) begin
      n_fail++;
      $display("FAIL err1: got %b want 0001", {PSEL, HREADY_OUT, HRESP});
    end
    tick(); drive_idle();
    PSLVERR = 1'b0;
    n_cmp++;
    if ({PSEL, HREADY_OUT, HRESP} !== 4'b0_1_01) begin
      n_fail++;
      $display("FAIL err2: got %b want 0101", {PSEL, HREADY_OUT, HRESP});
    end
    tick();
    n_cmp++;
    if ({PSEL, HREADY_OUT, HRESP} !== 4'b0_1_00 || HRDATA !== 32'hDEAD_BEEF || PADDR !== 32'h0000_0030) begin
      n_fail++;
      $display("FAIL err_idle: got %b hrdata %h paddr %h want 0100 hrdata deadbeef paddr 00000030", {PSEL, HREADY_OUT, HRESP}, HRDATA, PADDR);
    end
  endtask

  task automatic test_back_to_back();
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0BAD_F00D;
    drive_addr(1'b1, 2'b10, 32'h0000_0040, 1'b1);
    tick(); drive_idle();
    HWDATA = 32'hA5A5_0001;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b1_0_1 || PWDATA !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL b2b_wr_setup: got %b data %h want 101 data a5a50001", {PSEL, PENABLE, PWRITE}, PWDATA);
    end
    tick();
    tick();
    drive_addr(1'b1, 2'b11, 32'h0000_0044, 1'b0);
    n_cmp++;
    if ({PSEL, HREADY_OUT, HRESP} !== 4'b0_1_00) begin
      n_fail++;
      $display("FAIL b2b_done: got %b want 0100", {PSEL, HREADY_OUT, HRESP});
    end
    tick(); drive_idle();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, HREADY_OUT} !== 4'b1_0_0_0 || PADDR !== 32'h0000_0044) begin
      n_fail++;
      $display("FAIL b2b_rd_setup: got %b addr %h want 1000 addr 00000044", {PSEL, PENABLE, PWRITE, HREADY_OUT}, PADDR);
    end
    tick();
    tick();
    n_cmp++;
    if ({HREADY_OUT, HRESP} !== 3'b1_00 || HRDATA !== 32'h0BAD_F00D || PWDATA !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL b2b_rd_done: got %b hrdata %h pwdata %h want 100 hrdata 0badf00d pwdata a5a50001", {HREADY_OUT, HRESP}, HRDATA, PWDATA);
    end
    tick();
  endtask

  task automatic test_no_transfer();
    logic [1:0] trans_v [3];
    logic       sel_v   [3];
    trans_v[0] = 2'b00; sel_v[0] = 1'b1;
    trans_v[1] = 2'b01; sel_v[1] = 1'b1;
    trans_v[2] = 2'b10; sel_v[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_addr(sel_v[i], trans_v[i], 32'h0000_0060, 1'b1);
      tick();
      tick();
      n_cmp++;
      if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== 5'b0_0_1_00 || PADDR === 32'h0000_0060) begin
        n_fail++;
        $display("FAIL no_xfer%0d: got %b paddr %h want 00100 paddr unchanged", i, {PSEL, PENABLE, HREADY_OUT, HRESP}, PADDR);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_access();
    PREADY = 1'b0; PSLVERR = 1'b0;
    drive_addr(1'b1, 2'b10, 32'h0000_0050, 1'b0);
    tick(); drive_idle();
    tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got %b want 11", {PSEL, PENABLE});
    end
    HRESETn = 1'b0;
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== 5'b0_0_1_00 || HRDATA !== 32'h0 || PADDR !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got %b hrdata %h paddr %h want 00100 hrdata 0 paddr 0", {PSEL, PENABLE, HREADY_OUT, HRESP}, HRDATA, PADDR);
    end
    HRESETn = 1'b1;
    PREADY = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, HREADY_OUT, HRESP} !== 5'b0_0_1_00) begin
      n_fail++;
      $display("FAIL rst_mid_after: got %b want 00100", {PSEL, PENABLE, HREADY_OUT, HRESP});
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_read();
    test_write_wait();
    test_error();
    test_back_to_back();
    test_no_transfer();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
